// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory subsystem: MMIO base, register
// offsets and status/control bit positions.
package dmem_mmio_pkg;

    localparam logic [15:0] MMIO_BASE  = 16'hFFFF;

    localparam logic [7:0]  OFF_LED    = 8'h00;
    localparam logic [7:0]  OFF_CYCLE  = 8'h04;
    localparam logic [7:0]  OFF_TXDATA = 8'h08;
    localparam logic [7:0]  OFF_TXSTAT = 8'h0C;
    localparam logic [7:0]  OFF_TCMP   = 8'h10;
    localparam logic [7:0]  OFF_TCTRL  = 8'h14;
    localparam logic [7:0]  OFF_TCNT   = 8'h18;

    localparam int TXS_FULL   = 0;
    localparam int TXS_EMPTY  = 1;
    localparam int TXS_OVF    = 2;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_FLAG = 1;

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte FIFO for the TX port. Pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate count.
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [0:DEPTH-1];
    logic [AW:0] wrPtr, rdPtr;
    logic        doPush, doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign doPush = push && (!full || doPop);
    assign head   = empty ? 8'h00 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO window (LED, CYCLE, TX FIFO, optional compare timer).
// Define DMEM_MMIO_TIMER_EN to build the timer and irq.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_AW   = 6,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic [7:0]  led,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int RAM_WORDS = 1 << RAM_AW;

    logic [31:0]       ram [0:RAM_WORDS-1];
    logic              isMmio;
    logic [7:0]        off;
    logic [RAM_AW-1:0] ramIdx;
    logic [31:0]       cycleCnt;
    logic              txOvf, txFull, txEmpty, txPush, txPop;

    assign isMmio = (aluoutM[31:16] == MMIO_BASE);
    assign off    = aluoutM[7:0];
    assign ramIdx = aluoutM[RAM_AW+1:2];

    // Byte-offset bits and the gap between offset and base are don't-care.
    logic unusedAddr;
    assign unusedAddr = ^{aluoutM[1:0], aluoutM[15:8]};

    always_ff @(posedge clk) begin
        if (memwriteM && !isMmio) ram[ramIdx] <= writedataM;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led      <= 8'h00;
            cycleCnt <= 32'h0;
        end else begin
            cycleCnt <= cycleCnt + 32'h1;
            if (memwriteM && isMmio && off == OFF_LED) led <= writedataM[7:0];
        end
    end

    assign txPush   = memwriteM && isMmio && (off == OFF_TXDATA);
    assign txPop    = tx_valid && tx_ready;
    assign tx_valid = !txEmpty;

    tx_fifo #(.DEPTH(TX_DEPTH)) uTxFifo (
        .clk   (clk),
        .reset (reset),
        .push  (txPush),
        .pop   (txPop),
        .din   (writedataM[7:0]),
        .full  (txFull),
        .empty (txEmpty),
        .head  (tx_data)
    );

    // Overflow is sticky until any TX_STATUS write.
    always_ff @(posedge clk) begin
        if (reset)
            txOvf <= 1'b0;
        else if (txPush && txFull && !txPop)
            txOvf <= 1'b1;
        else if (memwriteM && isMmio && off == OFF_TXSTAT)
            txOvf <= 1'b0;
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] tmrCmp, tmrCnt;
    logic        tmrEn, tmrFlag, tmrMatch, ctrlWr;

    assign tmrMatch = tmrEn && (tmrCnt == tmrCmp);
    assign ctrlWr   = memwriteM && isMmio && (off == OFF_TCTRL);
    assign irq      = tmrFlag;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmrCmp  <= 32'h0;
            tmrCnt  <= 32'h0;
            tmrEn   <= 1'b0;
            tmrFlag <= 1'b0;
        end else begin
            if (memwriteM && isMmio && off == OFF_TCMP) tmrCmp <= writedataM;
            if (ctrlWr) tmrEn <= writedataM[TCTRL_EN];
            if (tmrMatch)   tmrCnt <= 32'h0;
            else if (tmrEn) tmrCnt <= tmrCnt + 32'h1;
            // Set beats a same-cycle write-1-to-clear.
            if (tmrMatch)                              tmrFlag <= 1'b1;
            else if (ctrlWr && writedataM[TCTRL_FLAG]) tmrFlag <= 1'b0;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdataM = 32'h0;
        if (isMmio) begin
            case (off)
                OFF_LED:    readdataM = {24'h0, led};
                OFF_CYCLE:  readdataM = cycleCnt;
                OFF_TXSTAT: begin
                    readdataM[TXS_FULL]  = txFull;
                    readdataM[TXS_EMPTY] = txEmpty;
                    readdataM[TXS_OVF]   = txOvf;
                end
`ifdef DMEM_MMIO_TIMER_EN
                OFF_TCMP:   readdataM = tmrCmp;
                OFF_TCTRL: begin
                    readdataM[TCTRL_EN]   = tmrEn;
                    readdataM[TCTRL_FLAG] = tmrFlag;
                end
                OFF_TCNT:   readdataM = tmrCnt;
`endif
                default:    readdataM = 32'h0;
            endcase
        end else begin
            readdataM = ram[ramIdx];
        end
    end

endmodule
